s8sp_datapath: RTL and testbench

// - S8SP register/ALU datapath directly downstream of sys_controller; consumes every ctrl_* strobe plus rd_mem/wr_mem.
// - Holds AR, DR, GR, PR, IR and a 4-bit flag register around one shared 8-bit internal data bus.
// - Owns the memory address/data interface.
// - Returns the IR to the controller as ctrl_ir_code.

---
 rtl/s8sp_pkg.sv | 29 ++
 rtl/s8sp_alu.sv | 58 +++++
 rtl/s8sp_datapath.sv | 122 ++++++++++++
 tb/tb_s8sp_datapath.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/s8sp_pkg.sv
// S8SP shared definitions: register codes, flag bit positions,
// and the bus driver bundle used by the datapath.
package s8sp_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    REG_AR = 2'b00,
    REG_DR = 2'b01,
    REG_GR = 2'b10,
    REG_PR = 2'b11
  } reg_sel_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  typedef struct packed {
    logic alu;
    logic flag;
    logic ir;
    logic ar;
    logic dr;
    logic gr;
    logic pr;
  } bus_drv_t;

endpackage

// File: rtl/s8sp_alu.sv
// S8SP ALU: operand muxes, add/subtract and {V,N,C,Z} generation.
// Purely combinational.
module s8sp_alu
  import s8sp_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [1:0]        oprnd1_sel,
  input  logic [1:0]        oprnd2_sel,
  input  logic              sub_nadd,
  input  logic [DATA_W-1:0] ar,
  input  logic [DATA_W-1:0] dr,
  input  logic [DATA_W-1:0] gr,
  input  logic [DATA_W-1:0] pr,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        flags
);

  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  logic [DATA_W-1:0] op2_x;
  logic [DATA_W:0]   sum;

  function automatic logic [DATA_W-1:0] pick(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] d,
    input logic [DATA_W-1:0] g,
    input logic [DATA_W-1:0] p
  );
    logic [DATA_W-1:0] v;
    v = a;
    unique case (reg_sel_e'(sel))
      REG_AR: v = a;
      REG_DR: v = d;
      REG_GR: v = g;
      REG_PR: v = p;
    endcase
    return v;
  endfunction

  always_comb begin
    op1   = pick(oprnd1_sel, ar, dr, gr, pr);
    op2   = pick(oprnd2_sel, ar, dr, gr, pr);
    op2_x = sub_nadd ? ~op2 : op2;
    // Subtract is op1 + ~op2 + 1, so carry-out means no borrow.
    sum   = {1'b0, op1} + {1'b0, op2_x}
          + {{DATA_W{1'b0}}, sub_nadd};
    result = sum[DATA_W-1:0];
    flags  = '0;
    flags[FLAG_C] = sum[DATA_W];
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_N] = result[DATA_W-1];
    flags[FLAG_V] = (op1[DATA_W-1] ^ result[DATA_W-1])
                  & (op2_x[DATA_W-1] ^ result[DATA_W-1]);
  end

endmodule

// File: rtl/s8sp_datapath.sv
// S8SP register/ALU datapath: AR, DR, GR, PR, IR, flags around one
// shared internal bus, plus the memory address/data interface.
module s8sp_datapath
  import s8sp_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter logic [DATA_W-1:0] PR_RESET = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_mem,
  input  logic              wr_mem,
  input  logic              ctrl_load_ar,
  input  logic              ctrl_ar_on_addr,
  input  logic              ctrl_ar_2_data,
  input  logic              ctrl_load_dr,
  input  logic              ctrl_dr_2_data,
  input  logic              ctrl_load_lsb_gr,
  input  logic              ctrl_load_msb_gr,
  input  logic              ctrl_gr_2_data,
  input  logic              ctrl_load_ar_2_pr,
  input  logic              ctrl_inc_pr,
  input  logic              ctrl_pr_2_data,
  input  logic              ctrl_pr_on_addr,
  input  logic              ctrl_load_ir,
  input  logic              ctrl_ir_2_data,
  input  logic              ctrl_alu_2_data,
  input  logic              ctrl_sub_nadd,
  input  logic [1:0]        ctrl_add_oprnd1_sel,
  input  logic [1:0]        ctrl_add_oprnd2_sel,
  input  logic              ctrl_flag_2_data,
  output logic [DATA_W-1:0] ctrl_ir_code,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              bus_conflict
);

  logic [DATA_W-1:0] ar_q, dr_q, gr_q, pr_q, ir_q;
  logic [3:0]        flag_q;
  logic [DATA_W-1:0] bus;
  logic [DATA_W-1:0] alu_r;
  logic [3:0]        alu_f;
  bus_drv_t          drv;
  logic              multi;

  s8sp_alu #(.DATA_W(DATA_W)) u_alu (
    .oprnd1_sel (ctrl_add_oprnd1_sel),
    .oprnd2_sel (ctrl_add_oprnd2_sel),
    .sub_nadd   (ctrl_sub_nadd),
    .ar         (ar_q),
    .dr         (dr_q),
    .gr         (gr_q),
    .pr         (pr_q),
    .result     (alu_r),
    .flags      (alu_f)
  );

  assign drv = '{
    alu:  ctrl_alu_2_data,
    flag: ctrl_flag_2_data,
    ir:   ctrl_ir_2_data,
    ar:   ctrl_ar_2_data,
    dr:   ctrl_dr_2_data,
    gr:   ctrl_gr_2_data,
    pr:   ctrl_pr_2_data
  };

  always_comb begin
    bus = '0;
    priority case (1'b1)
      drv.alu:  bus = alu_r;
      drv.flag: bus = {{(DATA_W-4){1'b0}}, flag_q};
      drv.ir:   bus = {(DATA_W/4){ir_q[3:0]}};
      drv.ar:   bus = ar_q;
      drv.dr:   bus = dr_q;
      drv.gr:   bus = gr_q;
      drv.pr:   bus = pr_q;
      rd_mem:   bus = mem_rdata;
      default:  bus = '0;
    endcase
  end

  always_comb begin
    mem_addr = '0;
    if (!reset) begin
      if (ctrl_pr_on_addr)      mem_addr = pr_q;
      else if (ctrl_ar_on_addr) mem_addr = ar_q;
    end
  end

  assign mem_wdata    = (!reset && wr_mem) ? bus : '0;
  assign ctrl_ir_code = ir_q;

  // Any internal driver alongside memory read also fights the bus.
  assign multi = ($countones(drv) > 1) || ((|drv) && rd_mem);

  always_ff @(posedge clk) begin
    if (reset) begin
      ar_q         <= '0;
      dr_q         <= '0;
      gr_q         <= '0;
      ir_q         <= '0;
      pr_q         <= PR_RESET;
      flag_q       <= '0;
      bus_conflict <= 1'b0;
    end else begin
      if (ctrl_load_ar)     ar_q <= bus;
      if (ctrl_load_dr)     dr_q <= bus;
      if (ctrl_load_lsb_gr) gr_q[3:0] <= bus[3:0];
      if (ctrl_load_msb_gr) gr_q[DATA_W-1:4] <= bus[DATA_W-1:4];
      if (ctrl_load_ir)     ir_q <= mem_rdata;
      if (ctrl_load_ar_2_pr)
        pr_q <= bus;
      else if (ctrl_inc_pr)
        pr_q <= pr_q + {{(DATA_W-1){1'b0}}, 1'b1};
      if (ctrl_alu_2_data)  flag_q <= alu_f;
      if (multi)            bus_conflict <= 1'b1;
    end
  end

endmodule

// File: tb/tb_s8sp_datapath.sv
// Directed bench for s8sp_datapath: scoreboard queue of expected
// register/output values, checked with immediate assertions.
module tb_s8sp_datapath;

  localparam logic [7:0] PRR = 8'h20;

  logic clk = 1'b0;
  logic reset;
  logic rd_mem, wr_mem;
  logic load_ar, ar_on_addr, ar_2_data;
  logic load_dr, dr_2_data;
  logic load_lsb_gr, load_msb_gr, gr_2_data;
  logic load_ar_2_pr, inc_pr, pr_2_data, pr_on_addr;
  logic load_ir, ir_2_data;
  logic alu_2_data, sub_nadd;
  logic [1:0] sel1, sel2;
  logic flag_2_data;
  logic [7:0] ir_code, mem_addr, mem_wdata, mem_rdata;
  logic bus_conflict;

  logic [7:0] mem [256];
  logic       use_mem;
  logic [7:0] rdata_drv;

  typedef struct {
    string      tag;
    logic [7:0] v;
  } exp_t;
  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign mem_rdata = use_mem ? mem[mem_addr] : rdata_drv;

  s8sp_datapath #(.DATA_W(8), .PR_RESET(PRR)) dut (
    .clk                 (clk),
    .reset               (reset),
    .rd_mem              (rd_mem),
    .wr_mem              (wr_mem),
    .ctrl_load_ar        (load_ar),
    .ctrl_ar_on_addr     (ar_on_addr),
    .ctrl_ar_2_data      (ar_2_data),
    .ctrl_load_dr        (load_dr),
    .ctrl_dr_2_data      (dr_2_data),
    .ctrl_load_lsb_gr    (load_lsb_gr),
    .ctrl_load_msb_gr    (load_msb_gr),
    .ctrl_gr_2_data      (gr_2_data),
    .ctrl_load_ar_2_pr   (load_ar_2_pr),
    .ctrl_inc_pr         (inc_pr),
    .ctrl_pr_2_data      (pr_2_data),
    .ctrl_pr_on_addr     (pr_on_addr),
    .ctrl_load_ir        (load_ir),
    .ctrl_ir_2_data      (ir_2_data),
    .ctrl_alu_2_data     (alu_2_data),
    .ctrl_sub_nadd       (sub_nadd),
    .ctrl_add_oprnd1_sel (sel1),
    .ctrl_add_oprnd2_sel (sel2),
    .ctrl_flag_2_data    (flag_2_data),
    .ctrl_ir_code        (ir_code),
    .mem_addr            (mem_addr),
    .mem_wdata           (mem_wdata),
    .mem_rdata           (mem_rdata),
    .bus_conflict        (bus_conflict)
  );

  task automatic clr();
    rd_mem = 0; wr_mem = 0;
    load_ar = 0; ar_on_addr = 0; ar_2_data = 0;
    load_dr = 0; dr_2_data = 0;
    load_lsb_gr = 0; load_msb_gr = 0; gr_2_data = 0;
    load_ar_2_pr = 0; inc_pr = 0; pr_2_data = 0; pr_on_addr = 0;
    load_ir = 0; ir_2_data = 0;
    alu_2_data = 0; sub_nadd = 0; sel1 = 2'b00; sel2 = 2'b00;
    flag_2_data = 0; use_mem = 0; rdata_drv = 8'h00;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic push(input string tag, input logic [7:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    exp_q.push_back(e);
  endtask

  task automatic obs(input logic [7:0] v);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%h", v);
    end else begin
      e = exp_q.pop_front();
      assert (v === e.v) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, v, e.v);
      end
    end
  endtask

  // 0 AR, 1 DR, 2 GR, 3 PR, 4 flags : read through mem_wdata
  task automatic peek(input int which);
    wr_mem = 1;
    case (which)
      0: ar_2_data = 1;
      1: dr_2_data = 1;
      2: gr_2_data = 1;
      3: pr_2_data = 1;
      default: flag_2_data = 1;
    endcase
    #1;
    obs(mem_wdata);
    clr();
  endtask

  task automatic ld(input int which, input logic [7:0] v);
    rd_mem = 1;
    rdata_drv = v;
    case (which)
      0: load_ar = 1;
      1: load_dr = 1;
      2: begin load_lsb_gr = 1; load_msb_gr = 1; end
      3: load_ar_2_pr = 1;
      default: load_ir = 1;
    endcase
    tick();
  endtask

  initial begin
    clr();
    for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'hA5);
    mem[8'h10] = 8'h52;
    reset = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;

    pr_on_addr = 1; wr_mem = 1; rd_mem = 1; rdata_drv = 8'hEE;
    push("rst_mem_addr", 8'h00);
    push("rst_mem_wdata", 8'h00);
    #1;
    obs(mem_addr);
    obs(mem_wdata);
    clr();
    tick();
    reset = 0;

    push("rst_ar", 8'h00); peek(0);
    push("rst_dr", 8'h00); peek(1);
    push("rst_gr", 8'h00); peek(2);
    push("rst_pr", PRR);   peek(3);
    push("rst_flags", 8'h00); peek(4);
    push("rst_ir", 8'h00); obs(ir_code);
    push("rst_conflict", 8'h00); obs({7'b0, bus_conflict});

    // Fetch
    ld(3, 8'h10);
    rd_mem = 1; pr_on_addr = 1; load_ir = 1; inc_pr = 1; use_mem = 1;
    push("fetch_addr", 8'h10);
    #1;
    obs(mem_addr);
    push("fetch_ir", 8'h52);
    push("fetch_pr", 8'h11);
    tick();
    obs(ir_code);
    peek(3);

    // ADD overflow
    ld(0, 8'h7F);
    ld(1, 8'h01);
    sel1 = 2'b00; sel2 = 2'b01; alu_2_data = 1; load_ar = 1; wr_mem = 1;
    push("add_bus", 8'h80);
    #1;
    obs(mem_wdata);
    push("add_ar", 8'h80);
    push("add_flags", 8'h0C);
    tick();
    peek(0);
    peek(4);
    tick();
    push("flags_hold", 8'h0C); peek(4);

    // SUB equal
    ld(1, 8'h33);
    ld(2, 8'h33);
    sel1 = 2'b01; sel2 = 2'b10; sub_nadd = 1; alu_2_data = 1; load_dr = 1;
    push("sub_dr", 8'h00);
    push("sub_flags", 8'h03);
    tick();
    peek(1);
    peek(4);

    // LLS / LMS
    ld(2, 8'h00);
    ld(4, 8'h7A);
    ir_2_data = 1; load_lsb_gr = 1;
    push("lls_gr", 8'h0A);
    tick();
    peek(2);
    ld(4, 8'h85);
    ir_2_data = 1; load_msb_gr = 1;
    push("lms_gr", 8'h5A);
    tick();
    peek(2);

    // PR wrap and load-over-increment priority
    ld(3, 8'hFF);
    inc_pr = 1;
    push("pr_wrap", 8'h00);
    tick();
    peek(3);
    ld(0, 8'h40);
    load_ar_2_pr = 1; inc_pr = 1; ar_2_data = 1;
    push("pr_load_prio", 8'h40);
    tick();
    peek(3);
    pr_on_addr = 1; ar_on_addr = 1;
    push("addr_prio", 8'h40);
    #1;
    obs(mem_addr);
    clr();
    push("no_conflict_yet", 8'h00); obs({7'b0, bus_conflict});

    // Conflict: AR beats DR on the bus
    ld(1, 8'h99);
    ar_2_data = 1; dr_2_data = 1; wr_mem = 1;
    push("bus_prio_ar", 8'h40);
    #1;
    obs(mem_wdata);
    tick();
    for (int i = 0; i < 3; i++) begin
      push($sformatf("conflict_hold%0d", i), 8'h01);
      obs({7'b0, bus_conflict});
      tick();
    end

    // Reset clears everything
    reset = 1;
    ar_2_data = 1; inc_pr = 1; load_ar = 1;
    tick();
    reset = 0;
    push("rst2_conflict", 8'h00); obs({7'b0, bus_conflict});
    push("rst2_pr", PRR);   peek(3);
    push("rst2_ar", 8'h00); peek(0);
    push("rst2_dr", 8'h00); peek(1);
    push("rst2_gr", 8'h00); peek(2);
    push("rst2_flags", 8'h00); peek(4);
    push("rst2_ir", 8'h00); obs(ir_code);

    // Driver together with memory read is a conflict
    rd_mem = 1; gr_2_data = 1;
    tick();
    push("rdmem_conflict", 8'h01); obs({7'b0, bus_conflict});

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
